// File: rtl/hazard_control.sv
// Pipeline stall/flush controller: load-use, instruction-RAM structural conflicts
// and taken branches, plus a saturating stall-cycle counter.
module hazard_control #(
  parameter logic [15:0] INST_LIMIT      = 16'h8000,
  parameter int unsigned CONFLICT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_reg1_addr,
  input  logic [3:0]  id_reg2_addr,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic        id_use_sp,
  input  logic        id_use_t,
  input  logic        id_branch_taken,
  input  logic        ieo_mem_read,
  input  logic        ieo_wr_reg,
  input  logic        ieo_wr_sp,
  input  logic        ieo_wr_t,
  input  logic [3:0]  ieo_wb_addr,
  input  logic        emo_ram_req,
  input  logic [15:0] emo_ram_addr,
  input  logic        perf_clr,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic        state,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 16;
  localparam logic        MULTI   = (CONFLICT_CYCLES > 1);
  // Remaining freeze cycles after entering CONFLICT (detection cycle already spent)
  localparam logic [CNT_W-1:0] CNT_INIT =
    MULTI ? CNT_W'(CONFLICT_CYCLES - 2) : '0;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_CONFLICT = 1'b1
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [STALL_W-1:0]   stall_q, stall_d;

  logic lu, cf, in_conf, freeze, last;

  assign lu = ieo_mem_read &
              ((ieo_wr_reg & id_use1 & (id_reg1_addr == ieo_wb_addr)) |
               (ieo_wr_reg & id_use2 & (id_reg2_addr == ieo_wb_addr)) |
               (ieo_wr_sp  & id_use_sp) |
               (ieo_wr_t   & id_use_t));

  assign cf      = emo_ram_req & (emo_ram_addr < INST_LIMIT);
  assign in_conf = (state_q == S_CONFLICT);
  assign freeze  = in_conf ? (cnt_q != '0) : (cf & MULTI);
  assign last    = in_conf ? (cnt_q == '0) : (cf & ~MULTI);

  // Latch controls; the IF fetch of a conflict's last cycle is discarded
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_hold = 1'b0;
    end else if (freeze) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b1;
      idex_hold    = 1'b1;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (last) begin
      if (lu) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else if (id_branch_taken) begin
        ifid_flush = 1'b1;
      end else begin
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
      end
    end else if (lu) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else if (id_branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (cf && MULTI) begin
            state_q <= S_CONFLICT;
            cnt_q   <= CNT_INIT;
          end
        end
        S_CONFLICT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q <= S_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (perf_clr) begin
      stall_d = '0;
    end else if (pc_hold && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign state        = in_conf;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: three instances (N = 2, 1, 4) driven in parallel and
// checked against a remaining-cycles model, plus table vectors and corner sequences.
module tb_hazard_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_reg1_addr, id_reg2_addr, ieo_wb_addr;
  logic        id_use1, id_use2, id_use_sp, id_use_t, id_branch_taken;
  logic        ieo_mem_read, ieo_wr_reg, ieo_wr_sp, ieo_wr_t;
  logic        emo_ram_req, perf_clr;
  logic [15:0] emo_ram_addr;

  logic [6:0]  o_a, o_b, o_c;
  logic        st_a, st_b, st_c;
  logic [15:0] sc_a, sc_b, sc_c;

  always #5 clk = ~clk;

  hazard_control #(.INST_LIMIT(16'h8000), .CONFLICT_CYCLES(2)) u_n2 (
    .clk(clk), .rst(rst), .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_use1(id_use1), .id_use2(id_use2), .id_use_sp(id_use_sp), .id_use_t(id_use_t),
    .id_branch_taken(id_branch_taken), .ieo_mem_read(ieo_mem_read), .ieo_wr_reg(ieo_wr_reg),
    .ieo_wr_sp(ieo_wr_sp), .ieo_wr_t(ieo_wr_t), .ieo_wb_addr(ieo_wb_addr),
    .emo_ram_req(emo_ram_req), .emo_ram_addr(emo_ram_addr), .perf_clr(perf_clr),
    .pc_hold(o_a[6]), .ifid_hold(o_a[5]), .idex_hold(o_a[4]), .exmem_hold(o_a[3]),
    .ifid_flush(o_a[2]), .idex_bubble(o_a[1]), .memwb_bubble(o_a[0]),
    .state(st_a), .stall_cycles(sc_a));

  hazard_control #(.INST_LIMIT(16'h8000), .CONFLICT_CYCLES(1)) u_n1 (
    .clk(clk), .rst(rst), .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_use1(id_use1), .id_use2(id_use2), .id_use_sp(id_use_sp), .id_use_t(id_use_t),
    .id_branch_taken(id_branch_taken), .ieo_mem_read(ieo_mem_read), .ieo_wr_reg(ieo_wr_reg),
    .ieo_wr_sp(ieo_wr_sp), .ieo_wr_t(ieo_wr_t), .ieo_wb_addr(ieo_wb_addr),
    .emo_ram_req(emo_ram_req), .emo_ram_addr(emo_ram_addr), .perf_clr(perf_clr),
    .pc_hold(o_b[6]), .ifid_hold(o_b[5]), .idex_hold(o_b[4]), .exmem_hold(o_b[3]),
    .ifid_flush(o_b[2]), .idex_bubble(o_b[1]), .memwb_bubble(o_b[0]),
    .state(st_b), .stall_cycles(sc_b));

  hazard_control #(.INST_LIMIT(16'h8000), .CONFLICT_CYCLES(4)) u_n4 (
    .clk(clk), .rst(rst), .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_use1(id_use1), .id_use2(id_use2), .id_use_sp(id_use_sp), .id_use_t(id_use_t),
    .id_branch_taken(id_branch_taken), .ieo_mem_read(ieo_mem_read), .ieo_wr_reg(ieo_wr_reg),
    .ieo_wr_sp(ieo_wr_sp), .ieo_wr_t(ieo_wr_t), .ieo_wb_addr(ieo_wb_addr),
    .emo_ram_req(emo_ram_req), .emo_ram_addr(emo_ram_addr), .perf_clr(perf_clr),
    .pc_hold(o_c[6]), .ifid_hold(o_c[5]), .idex_hold(o_c[4]), .exmem_hold(o_c[3]),
    .ifid_flush(o_c[2]), .idex_bubble(o_c[1]), .memwb_bubble(o_c[0]),
    .state(st_c), .stall_cycles(sc_c));

  // Output vector order: pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_bubble, memwb_bubble
  localparam logic [6:0] E_NONE   = 7'b000_0000;
  localparam logic [6:0] E_STALL  = 7'b110_0010;
  localparam logic [6:0] E_FLUSH  = 7'b000_0100;
  localparam logic [6:0] E_FREEZE = 7'b111_1001;
  localparam logic [6:0] E_LAST   = 7'b100_0100;

  int ns  [3] = '{2, 1, 4};
  int rem [3];   // cycles left in the current RAM access, 0 = none
  int mst [3];   // model stall counter
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic mr, wr, wsp, wt;
    logic [3:0] wb;
    logic u1, u2;
    logic [3:0] r1, r2;
    logic usp, ut, br, rq;
    logic [15:0] ra;
    logic [6:0] exp;
  } vec_t;

  vec_t tab [11];

  function automatic logic [6:0] dout(input int i);
    case (i)
      0:       return o_a;
      1:       return o_b;
      default: return o_c;
    endcase
  endfunction

  function automatic logic dstate(input int i);
    case (i)
      0:       return st_a;
      1:       return st_b;
      default: return st_c;
    endcase
  endfunction

  function automatic logic [15:0] dstall(input int i);
    case (i)
      0:       return sc_a;
      1:       return sc_b;
      default: return sc_c;
    endcase
  endfunction

  function automatic bit model_lu();
    return ieo_mem_read && ((ieo_wr_reg && id_use1 && id_reg1_addr == ieo_wb_addr) ||
                            (ieo_wr_reg && id_use2 && id_reg2_addr == ieo_wb_addr) ||
                            (ieo_wr_sp && id_use_sp) || (ieo_wr_t && id_use_t));
  endfunction

  function automatic logic [6:0] exp_out(input int r0, input int n, input bit lu,
                                         input bit br, input bit cf, input bit rs);
    int r;
    if (rs) return E_NONE;
    r = r0;
    if (r == 0 && cf) r = n;
    if (r > 1) return E_FREEZE;
    if (r == 1) begin
      if (lu) return E_STALL;
      if (br) return E_FLUSH;
      return E_LAST;
    end
    if (lu) return E_STALL;
    if (br) return E_FLUSH;
    return E_NONE;
  endfunction

  task automatic chk(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s[%0d] got %h exp %h at %0t", nm, i, got, exp, $time);
    else n_pass++;
  endtask

  // One clock: compare at negedge, advance the model, return just after posedge
  task automatic cyc(input bit do_chk, input int ti, input logic [6:0] texp);
    logic [6:0] e;
    bit lu, cf;
    int r;
    @(negedge clk);
    lu = model_lu();
    cf = emo_ram_req && (emo_ram_addr < 16'h8000);
    for (int i = 0; i < 3; i++) begin
      e = exp_out(rem[i], ns[i], lu, id_branch_taken, cf, rst);
      if (do_chk) begin
        chk("outs", i, 16'(dout(i)), 16'(e));
        chk("state", i, 16'(dstate(i)), (rst || rem[i] == 0) ? 16'd0 : 16'd1);
        chk("stall_cycles", i, dstall(i), rst ? 16'd0 : 16'(mst[i]));
      end
      if (rst) begin
        rem[i] = 0;
        mst[i] = 0;
      end else begin
        r = rem[i];
        if (r == 0 && cf) r = ns[i];
        if (r > 0) r--;
        rem[i] = r;
        if (perf_clr) mst[i] = 0;
        else if (e[6] && mst[i] < 65535) mst[i]++;
      end
    end
    if (do_chk && ti >= 0) chk("table", ti, 16'(dout(ti)), 16'(texp));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_reg1_addr = 4'd0; id_reg2_addr = 4'd0; ieo_wb_addr = 4'd0;
    id_use1 = 1'b0; id_use2 = 1'b0; id_use_sp = 1'b0; id_use_t = 1'b0;
    id_branch_taken = 1'b0; ieo_mem_read = 1'b0; ieo_wr_reg = 1'b0;
    ieo_wr_sp = 1'b0; ieo_wr_t = 1'b0; emo_ram_req = 1'b0;
    emo_ram_addr = 16'h0; perf_clr = 1'b0;
  endtask

  task automatic set_lu3();
    ieo_mem_read = 1'b1; ieo_wr_reg = 1'b1; ieo_wb_addr = 4'd3;
    id_use1 = 1'b1; id_reg1_addr = 4'd3;
  endtask

  initial begin
    //          mr wr sp t  wb  u1 u2 r1 r2 usp ut br rq ra        exp
    tab[0]  = '{1, 1, 0, 0, 3,  1, 0, 3, 0, 0,  0, 0, 0, 16'h0000, E_STALL};
    tab[1]  = '{1, 1, 0, 0, 3,  1, 0, 4, 0, 0,  0, 0, 0, 16'h0000, E_NONE};
    tab[2]  = '{1, 0, 1, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 16'h0000, E_STALL};
    tab[3]  = '{1, 0, 0, 1, 0,  0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, E_STALL};
    tab[4]  = '{1, 1, 0, 0, 9,  0, 1, 0, 9, 0,  0, 0, 0, 16'h0000, E_STALL};
    tab[5]  = '{0, 1, 1, 1, 3,  1, 0, 3, 0, 1,  1, 0, 0, 16'h0000, E_NONE};
    tab[6]  = '{1, 1, 0, 0, 3,  0, 0, 3, 3, 0,  0, 0, 0, 16'h0000, E_NONE};
    tab[7]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 16'h0000, E_FLUSH};
    tab[8]  = '{1, 1, 0, 0, 3,  1, 0, 3, 0, 0,  0, 1, 0, 16'h0000, E_STALL};
    tab[9]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 16'h8000, E_NONE};
    tab[10] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 1, 16'hFFFF, E_FLUSH};

    for (int i = 0; i < 3; i++) begin rem[i] = 0; mst[i] = 0; end
    idle();
    rst = 1'b1;
    #1;
    cyc(1, -1, E_NONE);
    cyc(1, -1, E_NONE);
    rst = 1'b0;
    cyc(1, 0, E_NONE);

    // Single-cycle vectors, all outside the instruction-RAM range
    for (int k = 0; k < 11; k++) begin
      ieo_mem_read = tab[k].mr; ieo_wr_reg = tab[k].wr; ieo_wr_sp = tab[k].wsp;
      ieo_wr_t = tab[k].wt; ieo_wb_addr = tab[k].wb; id_use1 = tab[k].u1;
      id_use2 = tab[k].u2; id_reg1_addr = tab[k].r1; id_reg2_addr = tab[k].r2;
      id_use_sp = tab[k].usp; id_use_t = tab[k].ut; id_branch_taken = tab[k].br;
      emo_ram_req = tab[k].rq; emo_ram_addr = tab[k].ra;
      cyc(1, 0, tab[k].exp);
    end
    idle();
    cyc(1, 0, E_NONE);

    // N=2 conflict at 0x4000, then release
    emo_ram_req = 1'b1; emo_ram_addr = 16'h4000;
    cyc(1, 0, E_FREEZE);
    chk("n2_state_after_detect", 0, 16'(st_a), 16'd1);
    emo_ram_req = 1'b0;
    cyc(1, 0, E_LAST);
    cyc(1, 0, E_NONE);
    chk("n2_state_idle", 0, 16'(st_a), 16'd0);

    // Back-to-back conflicts with the request held
    emo_ram_req = 1'b1;
    cyc(1, 0, E_FREEZE);
    cyc(1, 0, E_LAST);
    cyc(1, 0, E_FREEZE);
    idle();
    cyc(1, 0, E_LAST);
    cyc(1, -1, E_NONE);
    cyc(1, -1, E_NONE);
    cyc(1, -1, E_NONE);

    // N=1 last cycle with load-use, then with a taken branch
    emo_ram_req = 1'b1; emo_ram_addr = 16'h0010;
    set_lu3();
    cyc(1, 1, E_STALL);
    idle();
    cyc(1, -1, E_NONE);
    cyc(1, -1, E_NONE);
    cyc(1, -1, E_NONE);
    emo_ram_req = 1'b1; emo_ram_addr = 16'h7FFF; id_branch_taken = 1'b1;
    cyc(1, 1, E_FLUSH);
    idle();
    cyc(1, -1, E_NONE);
    cyc(1, -1, E_NONE);
    cyc(1, -1, E_NONE);

    // N=4: reset in the second CONFLICT cycle, then a full fresh sequence
    emo_ram_req = 1'b1; emo_ram_addr = 16'h1234;
    cyc(1, 2, E_FREEZE);
    emo_ram_req = 1'b0;
    cyc(1, 2, E_FREEZE);
    rst = 1'b1;
    #1;
    chk("n4_rst_outs", 2, 16'(o_c), 16'(E_NONE));
    chk("n4_rst_state", 2, 16'(st_c), 16'd0);
    cyc(1, 2, E_NONE);
    rst = 1'b0;
    emo_ram_req = 1'b1;
    cyc(1, 2, E_FREEZE);
    emo_ram_req = 1'b0;
    cyc(1, 2, E_FREEZE);
    cyc(1, 2, E_FREEZE);
    cyc(1, 2, E_LAST);
    cyc(1, 2, E_NONE);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      id_reg1_addr = 4'($urandom_range(0, 3)); id_reg2_addr = 4'($urandom_range(0, 3));
      ieo_wb_addr = 4'($urandom_range(0, 3));
      id_use1 = 1'($urandom); id_use2 = 1'($urandom);
      id_use_sp = 1'($urandom); id_use_t = 1'($urandom);
      id_branch_taken = 1'($urandom); ieo_mem_read = 1'($urandom);
      ieo_wr_reg = 1'($urandom); ieo_wr_sp = 1'($urandom); ieo_wr_t = 1'($urandom);
      emo_ram_req = ($urandom_range(0, 3) == 0);
      emo_ram_addr = 16'($urandom);
      perf_clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cyc(1, -1, E_NONE);
    end
    idle();
    rst = 1'b0;
    cyc(1, -1, E_NONE);

    // Saturation: 65534 unchecked stalls from zero, then checked cycles at the top
    rst = 1'b1;
    cyc(1, -1, E_NONE);
    rst = 1'b0;
    set_lu3();
    for (int k = 0; k < 65534; k++) cyc(0, -1, E_NONE);
    chk("sat_preload", 0, sc_a, 16'hFFFE);
    cyc(1, 0, E_STALL);
    cyc(1, 0, E_STALL);
    cyc(1, 0, E_STALL);
    chk("sat_hold", 0, sc_a, 16'hFFFF);
    perf_clr = 1'b1;
    cyc(1, 0, E_STALL);
    perf_clr = 1'b0;
    idle();
    chk("perf_clr", 0, sc_a, 16'h0000);
    cyc(1, 0, E_NONE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline stall/flush controller covering the hazards operand forwarding cannot resolve. It detects load-use hazards between the ID and EX stages, MEM-stage accesses to the shared instruction RAM (structural conflict, multi-cycle), and taken branches in ID. From these it drives per-latch hold, flush and bubble controls for the five-stage pipeline and keeps a saturating stall-cycle counter. It sits beside the forwarding unit and the pipeline latches, and its controls are consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.

## Interface
Parameters:
- `INST_LIMIT`, 16'h8000: MEM addresses below this value hit instruction RAM and cause a structural conflict.
- `CONFLICT_CYCLES`, 2: length of a conflicting RAM access in cycles; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_reg1_addr`, `id_reg2_addr` in 4: source register addresses of the instruction in ID.
- `id_use1`, `id_use2` in 1: the ID instruction consumes reg1/reg2 (ALU operand or store data).
- `id_use_sp`, `id_use_t` in 1: the ID instruction reads SP/T.
- `id_branch_taken` in 1: branch in ID resolved taken.
- `ieo_mem_read` in 1: the instruction in EX is a load.
- `ieo_wr_reg`, `ieo_wr_sp`, `ieo_wr_t` in 1: the EX instruction writes a GPR/SP/T.
- `ieo_wb_addr` in 4: GPR destination of the EX instruction.
- `emo_ram_req` in 1: the MEM stage performs a RAM read or write.
- `emo_ram_addr` in 16: the MEM stage RAM address.
- `perf_clr` in 1: synchronous clear of `stall_cycles`.
- `pc_hold`, `ifid_hold`, `idex_hold`, `exmem_hold` out 1: the latch keeps its value.
- `ifid_flush` out 1: load NOP into IF/ID.
- `idex_bubble` out 1: load NOP into ID/EX.
- `memwb_bubble` out 1: load NOP into MEM/WB.
- `state` out 1: 0 = RUN, 1 = CONFLICT.
- `stall_cycles` out 16: saturating count of cycles with `pc_hold` = 1.

## Operation
- `lu` (load-use) = `ieo_mem_read` & one of:
  - `ieo_wr_reg` & `id_use1` & `id_reg1_addr` == `ieo_wb_addr`
  - `ieo_wr_reg` & `id_use2` & `id_reg2_addr` == `ieo_wb_addr`
  - `ieo_wr_sp` & `id_use_sp`
  - `ieo_wr_t` & `id_use_t`
- `cf` (conflict) = `emo_ram_req` & (`emo_ram_addr` < `INST_LIMIT`), unsigned compare. It is sampled only in RUN.
- Phases of a conflicting access: the access spans `CONFLICT_CYCLES` cycles. The detection cycle in RUN counts as cycle 1.
  - Freeze cycles (1..N-1): `pc_hold`, `ifid_hold`, `idex_hold` and `exmem_hold` = 1, and `memwb_bubble` = 1. `lu` and branch are ignored.
  - Last cycle (N): the ID and later stages advance. The IF fetch failed, so `pc_hold` = 1 and `ifid_flush` = 1.
- FSM behaviour in RUN:
  - If `cf` and N = 1: last-cycle outputs; stay in RUN.
  - If `cf` and N > 1: freeze outputs; go to CONFLICT with cnt = N-2.
  - Otherwise: normal outputs.
- FSM behaviour in CONFLICT:
  - cnt > 0: freeze outputs, cnt-1.
  - cnt = 0: last-cycle outputs, then RUN.
- Normal outputs:
  - `lu`: `pc_hold` = `ifid_hold` = `idex_bubble` = 1. `id_branch_taken` is ignored, since the branch waits in ID.
  - Otherwise, if `id_branch_taken`: `ifid_flush` = 1.
- Last-cycle overrides:
  - With `lu`: `pc_hold` = `ifid_hold` = `idex_bubble` = 1 and `ifid_flush` = 0, so the ID instruction is kept.
  - With `id_branch_taken` and no `lu`: `pc_hold` = 0 so the PC takes the target, and `ifid_flush` = 1.
- Any output not named above is 0.
- `stall_cycles`:
  - +1 on each clock where `pc_hold` = 1; saturates at 16'hFFFF.
  - `perf_clr` has priority over the increment and loads 0.

## Timing
- All hold/flush/bubble outputs are combinational from the inputs and the FSM state, valid in the same cycle. The latches act on the next rising edge.
- The FSM, cnt and `stall_cycles` update on the rising edge of `clk`.
- Load-use costs exactly 1 stall cycle. A conflict costs N cycles with `pc_hold` = 1.
- While `rst` = 1:
  - All hold/flush/bubble outputs are forced to 0.
  - `state` = RUN, cnt = 0, `stall_cycles` = 0.
- Reset asserted mid-CONFLICT returns the FSM to RUN asynchronously. The first cycle after release evaluates as RUN.
- A back-to-back conflict (a new `cf` in the RUN cycle after the last cycle) restarts the sequence immediately.

## Test plan
- Load-use: `ieo_mem_read` = `ieo_wr_reg` = 1, `ieo_wb_addr` = 3, `id_use1` = 1, `id_reg1_addr` = 3 -> `pc_hold` = `ifid_hold` = `idex_bubble` = 1 that cycle and `stall_cycles` 0->1. Changing `id_reg1_addr` to 4 -> all outputs 0. With `ieo_wr_sp` = `id_use_sp` = 1 -> same stall.
- Conflict, N = 2, `emo_ram_addr` = 16'h4000 -> cycle 0: the four holds and `memwb_bubble` = 1, `state` -> 1. Cycle 1: only `pc_hold` and `ifid_flush` = 1. Cycle 2: `state` = 0, all 0. With addr 16'h8000 -> no action.
- Branch: `id_branch_taken` alone -> only `ifid_flush` = 1. Branch together with the load-use case -> `pc_hold` = `ifid_hold` = `idex_bubble` = 1 and `ifid_flush` = 0.
- Conflict last cycle (N = 1): with `lu` -> `pc_hold` = `ifid_hold` = `idex_bubble` = 1, `ifid_flush` = 0. With a taken branch -> `pc_hold` = 0, `ifid_flush` = 1.
- N = 4: assert `rst` in the second CONFLICT cycle -> outputs 0 immediately and `state` = 0. After release, a fresh `cf` restarts a full 4-cycle sequence.
- Preload to 16'hFFFE via held stalls: 3 more stall cycles -> `stall_cycles` = 16'hFFFF, with no wrap. Then `perf_clr` together with a stall -> 0.
